sram_arbiter: RTL

- Sequences and shares the single off-chip SRAM between two requesters: port 0 is CPU datapath memory traffic (MAR/MDR fetch/load/store), port 1 is the debug/program-loader port.
- Replaces direct state-driven Mem_OE/Mem_WE strobing in the control unit with a request/acknowledge handshake.
- Round-robin grant; fixed multi-cycle SRAM access timing.
- Sits between the control unit/datapath and the top-level SRAM pins; the tri-state data bus is handled outside this block.

---
 rtl/lc3b_types.sv | 19 +
 rtl/rr_arbiter2.sv | 23 ++
 rtl/sram_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b types: SRAM arbiter state encoding, port index, timing default.
// SRAM_TURNAROUND_EN adds the TURN state used after writes.
package lc3b_types;

   localparam int SRAM_ACC_CYCLES = 2;

   typedef logic mem_port_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
`ifdef SRAM_TURNAROUND_EN
      ,
      ST_TURN   = 2'd3
`endif
   } arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: with both requesting, the port not served last wins.
// Ports: i_req0/i_req1 requests, i_last last served port, o_valid any grant, o_port winner.
module rr_arbiter2
   import lc3b_types::*;
(
   input  logic      i_req0,
   input  logic      i_req1,
   input  mem_port_t i_last,
   output logic      o_valid,
   output mem_port_t o_port
);

   assign o_valid = i_req0 | i_req1;

   always_comb begin
      o_port = 1'b0;
      if (i_req0 && i_req1)
         o_port = ~i_last;
      else if (i_req1)
         o_port = 1'b1;
   end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one asynchronous SRAM between the CPU (port 0) and debug loader (port 1)
// with req/ack handshakes and fixed ACC_CYCLES strobe timing.
// Ports: Clk/Reset (async, active low); reqN/weN/addrN/wdataN in, ackN out;
// rdata read result; Mem_* SRAM strobes/address/data (active-low strobes);
// busy = not IDLE. Macro SRAM_TURNAROUND_EN inserts a TURN cycle after writes.
module sram_arbiter
   import lc3b_types::*;
#(
   parameter int ADDR_W     = 20,
   parameter int DATA_W     = 16,
   parameter int ACC_CYCLES = SRAM_ACC_CYCLES
)(
   input  logic              Clk,
   input  logic              Reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [15:0]       addr0,
   input  logic [15:0]       addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack0,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata,
   output logic              Mem_CE,
   output logic              Mem_UB,
   output logic              Mem_LB,
   output logic              Mem_OE,
   output logic              Mem_WE,
   output logic [ADDR_W-1:0] Mem_ADDR,
   output logic [DATA_W-1:0] Mem_WDATA,
   output logic              Mem_DRIVE,
   input  logic [DATA_W-1:0] Mem_RDATA,
   output logic              busy
);

   localparam logic [3:0] CNT_INIT = 4'(ACC_CYCLES - 1);

   arb_state_t        r_state;
   arb_state_t        w_next;
   mem_port_t         r_last;
   mem_port_t         r_port;
   logic              r_we;
   logic [15:0]       r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata;
   logic [3:0]        r_cnt;

   logic              w_gnt_valid;
   mem_port_t         w_gnt_port;

   rr_arbiter2 u_rr (
      .i_req0  (req0),
      .i_req1  (req1),
      .i_last  (r_last),
      .o_valid (w_gnt_valid),
      .o_port  (w_gnt_port)
   );

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset)
         r_state <= ST_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:
            if (w_gnt_valid)
               w_next = ST_ACCESS;
         ST_ACCESS:
            if (r_cnt == 4'd0)
               w_next = ST_DONE;
`ifdef SRAM_TURNAROUND_EN
         ST_DONE:
            w_next = r_we ? ST_TURN : ST_IDLE;
         ST_TURN:
            w_next = ST_IDLE;
`else
         ST_DONE:
            w_next = ST_IDLE;
`endif
         default:
            w_next = ST_IDLE;
      endcase
   end

   // Request fields are captured once at grant so mid-access input
   // changes cannot disturb the SRAM cycle.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_last  <= 1'b1;
         r_port  <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            ST_IDLE:
               if (w_gnt_valid) begin
                  r_port  <= w_gnt_port;
                  r_last  <= w_gnt_port;
                  r_we    <= w_gnt_port ? we1 : we0;
                  r_addr  <= w_gnt_port ? addr1 : addr0;
                  r_wdata <= w_gnt_port ? wdata1 : wdata0;
                  r_cnt   <= CNT_INIT;
               end
            ST_ACCESS:
               if (r_cnt != 4'd0)
                  r_cnt <= r_cnt - 4'd1;
               else if (!r_we)
                  r_rdata <= Mem_RDATA;
            default: ;
         endcase
      end
   end

   // Strobes decode from state only, so they stay steady across ACCESS.
   always_comb begin
      Mem_CE    = 1'b1;
      Mem_UB    = 1'b1;
      Mem_LB    = 1'b1;
      Mem_OE    = 1'b1;
      Mem_WE    = 1'b1;
      Mem_ADDR  = '0;
      Mem_WDATA = '0;
      Mem_DRIVE = 1'b0;
      ack0      = 1'b0;
      ack1      = 1'b0;
      case (r_state)
         ST_ACCESS: begin
            Mem_CE   = 1'b0;
            Mem_UB   = 1'b0;
            Mem_LB   = 1'b0;
            Mem_ADDR = ADDR_W'(r_addr);
            if (r_we) begin
               Mem_WE    = 1'b0;
               Mem_DRIVE = 1'b1;
               Mem_WDATA = r_wdata;
            end else begin
               Mem_OE = 1'b0;
            end
         end
         ST_DONE: begin
            ack0 = (r_port == 1'b0);
            ack1 = (r_port == 1'b1);
         end
         default: ;
      endcase
   end

   assign rdata = r_rdata;
   assign busy  = (r_state != ST_IDLE);

endmodule
